// File: rtl/bitrev_stream_buf.sv
// Streaming bit-reversal reorder buffer.
// Samples arrive in natural order, one per cycle, and each N-sample frame is
// emitted in bit-reversed order. Two frame banks ping-pong so the next frame
// can be written while the previous one drains.
module bitrev_stream_buf #(
    parameter int unsigned IDX_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int unsigned        IDX_SIZE = 2 ** IDX_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(IDX_SIZE - 1);

    // Reverse the bit order of a frame index.
    function automatic logic [IDX_WIDTH-1:0] bitrev(input logic [IDX_WIDTH-1:0] idx);
        logic [IDX_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < int'(IDX_WIDTH); b++) begin
            r[b] = idx[int'(IDX_WIDTH) - 1 - b];
        end
        return r;
    endfunction

    // Frame storage: bank contents are deliberately not reset.
    logic [DATA_WIDTH-1:0] mem_q [2][IDX_SIZE];

    // Control state.
    logic [1:0]           full_q,    full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [IDX_WIDTH-1:0] wr_cnt_q,  wr_cnt_d;
    logic [IDX_WIDTH-1:0] rd_cnt_q,  rd_cnt_d;

    // Registered outputs.
    logic                  in_ready_q,  in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q,  out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;

    // Transfer qualifiers, derived from registered state only.
    logic                 wr_fire;
    logic                 rd_fire;
    logic [IDX_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] rd_word;

    // Handshake decode: a transfer needs the target bank in the right state.
    always_comb begin
        wr_fire = in_valid  && !full_q[wr_bank_q];
        rd_fire = out_ready &&  full_q[rd_bank_q];
        wr_addr = bitrev(wr_cnt_q);
    end

    // Next-state logic for counters, bank pointers and full flags.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;

        if (wr_fire) begin
            if (wr_cnt_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_cnt_d          = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + IDX_WIDTH'(1);
            end
        end

        // The read bank is always the other bank when a write completes,
        // so the set above and the clear below never collide.
        if (rd_fire) begin
            if (rd_cnt_q == LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                rd_cnt_d          = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + IDX_WIDTH'(1);
            end
        end
    end

    // Output look-ahead: compute next-cycle outputs from next-state values.
    always_comb begin
        in_ready_d  = !full_d[wr_bank_d];
        out_valid_d =  full_d[rd_bank_d];
        out_last_d  =  full_d[rd_bank_d] && (rd_cnt_d == LAST_IDX);

        // Forward the sample being written this cycle if it is the one read next.
        rd_word = mem_q[rd_bank_d][rd_cnt_d];
        if (wr_fire && (wr_bank_q == rd_bank_d) && (wr_addr == rd_cnt_d)) begin
            rd_word = in_data;
        end
        out_data_d = out_valid_d ? rd_word : '0;
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Sample storage: write lands at the bit-reversed slot of the write bank.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_addr] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule
